// File: rtl/pmp_seq_checker_pkg.sv
// Shared types and constants for the sequential PMP checker.
//   pmp_cfg_t        : one pmpcfg byte {L, rsvd[1:0], A[1:0], X, W, R}
//   pmp_req_type_e   : access type of a request (encoding 2'b11 is reserved)
//   pmp_chk_state_e  : checker FSM states, mirrored as plain localparams
//   OFF/TOR/NA4/NAPOT: address-matching modes carried in pmpcfg.A
//   pmp_perm_fault() : permission decision for a matched entry
package pmp_seq_checker_pkg;

   typedef struct packed {
      logic       l;
      logic [1:0] rsvd;
      logic [1:0] a;
      logic       x;
      logic       w;
      logic       r;
   } pmp_cfg_t;

   typedef enum logic [1:0] {
      PMP_R = 2'b00,
      PMP_W = 2'b01,
      PMP_X = 2'b10
   } pmp_req_type_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      RESP = 2'd2
   } pmp_chk_state_e;

   // Flat state encodings used by the FSM register.
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SCAN = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   // pmpcfg.A matching modes.
   localparam logic [1:0] OFF   = 2'b00;
   localparam logic [1:0] TOR   = 2'b01;
   localparam logic [1:0] NA4   = 2'b10;
   localparam logic [1:0] NAPOT = 2'b11;

   // Fault decision once an entry has matched. The reserved type faults
   // unconditionally; machine mode bypasses unlocked entries; otherwise the
   // entry's R/W/X bit for the access type decides.
   function automatic logic pmp_perm_fault(input pmp_cfg_t   cfg,
                                           input logic [1:0] req_type,
                                           input logic       priv_m);
      logic fault;
      fault = 1'b1;
      if (req_type == 2'b11) begin
         fault = 1'b1;
      end else if (priv_m && !cfg.l) begin
         fault = 1'b0;
      end else begin
         case (req_type)
            PMP_R:   fault = !cfg.r;
            PMP_W:   fault = !cfg.w;
            default: fault = !cfg.x;
         endcase
      end
      return fault;
   endfunction

endpackage

// File: rtl/pmp_seq_checker_addr_check.sv
// Address match for a single PMP entry (combinational).
//   addr          : request address in pmpaddr units
//   mode          : pmpcfg.A of this entry
//   pmp_addr      : this entry's pmpaddr
//   pmp_addr_last : previous entry's pmpaddr (0 for entry 0), TOR lower bound
//   napot_mask    : NAPOT compare mask from the CSR block
//   hit           : entry matches addr
module pmp_addr_check
   import pmp_seq_checker_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [1:0]            mode,
   input  logic [ADDR_WIDTH-1:0] pmp_addr,
   input  logic [ADDR_WIDTH-1:0] pmp_addr_last,
   input  logic [ADDR_WIDTH-1:0] napot_mask,
   output logic                  hit
);

   always_comb begin
      hit = 1'b0;
      case (mode)
         OFF:   hit = 1'b0;
         // An empty or inverted TOR range never matches; the range check
         // alone already guarantees that, the explicit term documents it.
         TOR:   hit = (pmp_addr_last < pmp_addr) &&
                      (addr >= pmp_addr_last) && (addr < pmp_addr);
         NA4:   hit = (addr == pmp_addr);
         NAPOT: hit = (((addr ^ pmp_addr) & napot_mask) == '0);
         default: hit = 1'b0;
      endcase
   end

endmodule

// File: rtl/pmp_seq_checker.sv
// Sequential PMP permission checker. One request is accepted per handshake;
// LANES entries are examined per SCAN cycle, lowest-numbered match wins.
//   clk, rst         : clock, synchronous active-high reset
//   req_vld/req_rdy  : request handshake (req_rdy high only in IDLE)
//   req_addr         : address to check (pmpaddr units)
//   req_type         : 00 R, 01 W, 10 X, 11 reserved (always faults)
//   req_priv_m       : 1 = machine mode
//   pmp_cfg          : per-entry cfg bytes
//   pmp_addr         : per-entry pmpaddr
//   pmp_napot_mask   : per-entry NAPOT mask
//   resp_vld/resp_rdy: response handshake; resp_* held while resp_vld & !resp_rdy
//   resp_fault       : access fault
//   resp_hit         : an entry matched
//   resp_idx         : matching entry, 0 when no hit
//
// Handshake rule: a transfer happens on a rising edge where both vld and rdy
// are high; the sender holds its payload stable while vld is high and rdy low.
module pmp_seq_checker
   import pmp_seq_checker_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int PMP_NUM    = 16,
   parameter int LANES      = 4
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                req_vld,
   output logic                                req_rdy,
   input  logic [ADDR_WIDTH-1:0]               req_addr,
   input  logic [1:0]                          req_type,
   input  logic                                req_priv_m,
   input  logic [PMP_NUM-1:0][7:0]             pmp_cfg,
   input  logic [PMP_NUM-1:0][ADDR_WIDTH-1:0]  pmp_addr,
   input  logic [PMP_NUM-1:0][ADDR_WIDTH-1:0]  pmp_napot_mask,
   output logic                                resp_vld,
   input  logic                                resp_rdy,
   output logic                                resp_fault,
   output logic                                resp_hit,
   output logic [$clog2(PMP_NUM)-1:0]          resp_idx
);

   localparam int IDX_W      = $clog2(PMP_NUM);
   localparam int NUM_GROUPS = PMP_NUM / LANES;
   localparam int G_W        = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
   localparam int LW         = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [G_W-1:0] LAST_G = G_W'(NUM_GROUPS - 1);

   // ---------------------------------------------------------------------
   // State and latched request
   // ---------------------------------------------------------------------
   logic [1:0]            state;
   logic [G_W-1:0]        grp;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [1:0]            type_q;
   logic                  priv_q;

   // ---------------------------------------------------------------------
   // Lane mux: group grp selects entries grp*LANES .. grp*LANES+LANES-1
   // ---------------------------------------------------------------------
   logic [IDX_W-1:0]      lane_idx  [LANES];
   logic [ADDR_WIDTH-1:0] lane_addr [LANES];
   logic [ADDR_WIDTH-1:0] lane_last [LANES];
   logic [ADDR_WIDTH-1:0] lane_mask [LANES];
   pmp_cfg_t              lane_cfg  [LANES];
   logic [LANES-1:0]      lane_hit;

   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         lane_idx[l]  = IDX_W'(int'(grp) * LANES + l);
         lane_addr[l] = pmp_addr[lane_idx[l]];
         // Entry 0 has no predecessor: its TOR lower bound is address 0.
         lane_last[l] = (lane_idx[l] == '0) ? '0
                                            : pmp_addr[lane_idx[l] - IDX_W'(1)];
         lane_mask[l] = pmp_napot_mask[lane_idx[l]];
         lane_cfg[l]  = pmp_cfg_t'(pmp_cfg[lane_idx[l]]);
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      pmp_addr_check #(
         .ADDR_WIDTH (ADDR_WIDTH)
      ) u_check (
         .addr          (addr_q),
         .mode          (lane_cfg[l].a),
         .pmp_addr      (lane_addr[l]),
         .pmp_addr_last (lane_last[l]),
         .napot_mask    (lane_mask[l]),
         .hit           (lane_hit[l])
      );
   end

   // Reserved cfg bits carry no meaning here.
   logic unused_rsvd;
   always_comb begin
      unused_rsvd = 1'b0;
      for (int l = 0; l < LANES; l++) unused_rsvd = unused_rsvd ^ (^lane_cfg[l].rsvd);
   end

   // ---------------------------------------------------------------------
   // Lane priority: lowest set lane index
   // ---------------------------------------------------------------------
   function automatic logic [LW-1:0] lowest_set(input logic [LANES-1:0] v);
      logic [LW-1:0] r;
      r = '0;
      for (int i = LANES - 1; i >= 0; i--) begin
         if (v[i]) r = LW'(i);
      end
      return r;
   endfunction

   logic [LW-1:0]    sel;
   logic             any_hit;
   logic [IDX_W-1:0] sel_idx;
   logic             hit_fault;
   logic             miss_fault;

   always_comb begin
      sel        = lowest_set(lane_hit);
      any_hit    = |lane_hit;
      sel_idx    = lane_idx[sel];
      hit_fault  = pmp_perm_fault(lane_cfg[sel], type_q, priv_q);
      // No entry matched: machine mode is allowed, S/U faults. The reserved
      // type faults regardless of privilege.
      miss_fault = !priv_q || (type_q == 2'b11);
   end

   // ---------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         grp        <= '0;
         addr_q     <= '0;
         type_q     <= '0;
         priv_q     <= 1'b0;
         resp_fault <= 1'b0;
         resp_hit   <= 1'b0;
         resp_idx   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_vld) begin
                  addr_q <= req_addr;
                  type_q <= req_type;
                  priv_q <= req_priv_m;
                  grp    <= '0;
                  state  <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (any_hit) begin
                  resp_hit   <= 1'b1;
                  resp_idx   <= sel_idx;
                  resp_fault <= hit_fault;
                  state      <= S_RESP;
               end else if (grp == LAST_G) begin
                  resp_hit   <= 1'b0;
                  resp_idx   <= '0;
                  resp_fault <= miss_fault;
                  state      <= S_RESP;
               end else begin
                  grp <= grp + G_W'(1);
               end
            end
            S_RESP: begin
               if (resp_rdy) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign req_rdy  = (state == S_IDLE);
   assign resp_vld = (state == S_RESP);

endmodule
